// File: rtl/gan_stream_pkg.sv
// Shared types and defaults for the generator-datapath stream bridges.
package gan_stream_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_FRAME_LEN   = 169;
  localparam int STALL_CNT_WIDTH = 32;

endpackage

// File: rtl/stream_skid_buf2.sv
// Two-entry in-order queue; the head slot is a register so m_data never sees fifo_rd_data combinationally.
module stream_skid_buf2
  import gan_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  valid
);

  occ_e                  occ_r, occ_nxt_s;
  logic [DATA_WIDTH-1:0] slot0_r, slot1_r, slot0_nxt_s, slot1_nxt_s;

  // Next queue contents; pop is only ever asserted while the queue is non-empty.
  always_comb begin
    occ_nxt_s   = occ_r;
    slot0_nxt_s = slot0_r;
    slot1_nxt_s = slot1_r;
    case (occ_r)
      OCC_EMPTY: begin
        if (push) begin
          slot0_nxt_s = push_data;
          occ_nxt_s   = OCC_ONE;
        end else begin
          occ_nxt_s = OCC_EMPTY;
        end
      end
      OCC_ONE: begin
        if (push && pop) begin
          slot0_nxt_s = push_data;
        end else if (push) begin
          slot1_nxt_s = push_data;
          occ_nxt_s   = OCC_TWO;
        end else if (pop) begin
          occ_nxt_s = OCC_EMPTY;
        end else begin
          occ_nxt_s = OCC_ONE;
        end
      end
      OCC_TWO: begin
        if (pop) begin
          slot0_nxt_s = slot1_r;
          if (push) begin
            slot1_nxt_s = push_data;
          end else begin
            occ_nxt_s = OCC_ONE;
          end
        end else begin
          occ_nxt_s = OCC_TWO;
        end
      end
      default: occ_nxt_s = OCC_EMPTY;
    endcase
  end

  // Queue state register; clr empties the queue but leaves the stale head data in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_r   <= OCC_EMPTY;
      slot0_r <= {DATA_WIDTH{1'b0}};
      slot1_r <= {DATA_WIDTH{1'b0}};
    end else if (clr) begin
      occ_r <= OCC_EMPTY;
    end else begin
      occ_r   <= occ_nxt_s;
      slot0_r <= slot0_nxt_s;
      slot1_r <= slot1_nxt_s;
    end
  end

  assign occ       = occ_r;
  assign head_data = slot0_r;
  assign valid     = (occ_r != OCC_EMPTY);

  stream_skid_buf2_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .push (push),
    .pop  (pop),
    .occ  (occ)
  );

endmodule

// File: rtl/stream_skid_buf2_chk.sv
// Property checker for the 2-entry skid queue: never push into a full queue without a pop.
module stream_skid_buf2_chk
  import gan_stream_pkg::*;
(
  input logic       clk,
  input logic       rst,
  input logic       clr,
  input logic       push,
  input logic       pop,
  input logic [1:0] occ
);

  no_push_into_full_a : assert property (
    @(posedge clk) disable iff (rst || clr) !(push && !pop && (occ == OCC_TWO))
  );

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO read front end: read credits, in-flight tracking, frame delimiting and optional stall
// statistics (enabled by defining FIFO_STREAM_READER_STATS_EN).
module fifo_stream_reader
  import gan_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAME_LEN  = DEF_FRAME_LEN,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       fifo_empty,
  output logic                       fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]      fifo_rd_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_WIDTH-1:0]      m_data,
  output logic                       m_last,
  output logic                       frame_done,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt
);

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(FRAME_LEN - 1);

  logic                 inflight_r;
  logic                 pop_s;
  logic                 push_s;
  logic                 rd_en_s;
  logic [1:0]           occ_s;
  logic [2:0]           credit_s;
  logic                 last_beat_s;
  logic [CNT_WIDTH-1:0] beat_cnt_r;
  logic                 frame_done_r;

  assign pop_s       = m_valid & m_ready;
  assign push_s      = inflight_r & ~flush;
  assign last_beat_s = (beat_cnt_r == LAST_IDX);

  // Issue a read only when queue plus in-flight word, after this cycle's pop, leaves a free slot.
  always_comb begin
    credit_s = {1'b0, occ_s} + {2'b00, inflight_r} - {2'b00, pop_s};
    if (rst || flush || fifo_empty) begin
      rd_en_s = 1'b0;
    end else begin
      rd_en_s = (credit_s < 3'd2);
    end
  end

  assign fifo_rd_en = rd_en_s;

  // Tracks the read issued last cycle, whose data lands now.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= rd_en_s;
    end
  end

  stream_skid_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .push      (push_s),
    .push_data (fifo_rd_data),
    .pop       (pop_s),
    .occ       (occ_s),
    .head_data (m_data),
    .valid     (m_valid)
  );

  // Beat position within the frame and the end-of-frame pulse.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      beat_cnt_r   <= {CNT_WIDTH{1'b0}};
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= pop_s & last_beat_s;
      if (pop_s) begin
        beat_cnt_r <= last_beat_s ? {CNT_WIDTH{1'b0}} : beat_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        beat_cnt_r <= beat_cnt_r;
      end
    end
  end

  assign m_last     = m_valid & last_beat_s;
  assign frame_done = frame_done_r;

`ifdef FIFO_STREAM_READER_STATS_EN
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_r;

  // Saturating count of cycles the downstream holds off a valid beat.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      stall_cnt_r <= {STALL_CNT_WIDTH{1'b0}};
    end else if (m_valid && !m_ready && (stall_cnt_r != {STALL_CNT_WIDTH{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  assign stall_cnt = {STALL_CNT_WIDTH{1'b0}};
`endif

endmodule
